store_buffer: RTL and testbench

Data-side memory adapter between the CPU's MEM stage and a slower external memory bus. Stores from the pipeline are accepted without stalling into a small in-order FIFO and drained to memory in the background. Loads are satisfied by forwarding from buffered stores or by a blocking memory read that stalls the pipeline. It replaces the CPU's single-cycle data memory with a handshaked bus while keeping the MEM-stage port contract: combinational read data plus a stall.

---
 rtl/cpu_mem_pkg.sv | 11 +
 rtl/store_fifo.sv | 67 ++++++
 rtl/store_buffer.sv | 99 +++++++++
 tb/tb_store_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types, default widths and address helper for the store buffer.
package cpu_mem_pkg;
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} sb_state_e;
    // True when two byte addresses fall in the same 32-bit word (callers zero-extend).
    function automatic logic same_word(input logic [63:0] a, input logic [63:0] b);
        return ((a ^ b) >> 2) == 64'd0;
    endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: in-order store queue with youngest-match lookup.
// Ports: clk/reset (async active-low); push/push_addr/push_data enqueue at tail;
// pop dequeues head; head_addr/head_data show the oldest entry; full/empty flags;
// look_addr is compared against all valid entries, hit/hit_data report the youngest match.
module store_fifo
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] look_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count;
    logic              do_push, do_pop;
    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop) head <= head + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end
    // Walk oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && same_word(64'(look_addr), 64'(addr_mem[head + PW'(i)]))) begin
                hit      = 1'b1;
                hit_data = data_mem[head + PW'(i)];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage adapter that buffers stores, forwards loads and drains to a handshaked bus.
// Ports: clk/reset (async active-low); cpu_we/cpu_re/cpu_addr/cpu_wdata from the pipeline,
// cpu_rdata/cpu_stall back to it; mem_req/mem_we/mem_addr/mem_wdata registered bus outputs,
// mem_ack/mem_rdata bus completion inputs.
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
    sb_state_e         state, next_state;
    logic              full, empty, hit, pop, start_read, start_write;
    logic [ADDR_W-1:0] head_addr, word_addr;
    logic [DATA_W-1:0] head_data, hit_data, rdata_q;
    assign word_addr = cpu_addr & ALIGN;
    assign pop       = state == DRAIN && mem_ack;
    store_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cpu_we),
        .push_addr (word_addr),
        .push_data (cpu_wdata),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .look_addr (cpu_addr),
        .hit       (hit),
        .hit_data  (hit_data)
    );
    // Combinational outputs are forced low during reset since they bypass the registers.
    assign cpu_rdata = !reset ? '0 : (state == RESP ? rdata_q : hit_data);
    assign cpu_stall = !reset ? 1'b0 : (cpu_we & full) | (cpu_re & ~hit & (state != RESP));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end
    // A load miss wins over draining so the stalled pipeline resumes as early as possible.
    always_comb begin
        next_state  = state;
        start_read  = 1'b0;
        start_write = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_re && !hit) begin
                    start_read = 1'b1;
                    next_state = READ;
                end else if (!empty) begin
                    start_write = 1'b1;
                    next_state  = DRAIN;
                end
            end
            DRAIN:   next_state = mem_ack ? IDLE : DRAIN;
            READ:    next_state = mem_ack ? RESP : READ;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (start_read) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= word_addr;
            end else if (start_write) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
            end else if ((state == DRAIN || state == READ) && mem_ack) begin
                mem_req <= 1'b0;
            end
            if (state == READ && mem_ack) rdata_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table plus multi-cycle sequences for store_buffer.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_re, mem_ack;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, mem_req, mem_we;
    int          n_cmp = 0;
    int          n_bad = 0;

    store_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we, re, ack;
        logic [31:0] addr, wdata, mrdata;
        logic        e_stall, e_req, e_mwe;
        logic [31:0] e_rdata, e_maddr, e_mwdata;
    } vec_t;
    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic quiet(input string name);
        bit seen;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= mem_req;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    function automatic vec_t mk(logic we, logic re, logic [31:0] addr, logic [31:0] wdata,
                                logic ack, logic [31:0] mrdata, logic e_stall,
                                logic [31:0] e_rdata, logic e_req, logic e_mwe,
                                logic [31:0] e_maddr, logic [31:0] e_mwdata);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.ack = ack; v.mrdata = mrdata;
        v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_req = e_req; v.e_mwe = e_mwe;
        v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        return v;
    endfunction

    initial begin
        bit ok;
        logic [31:0] exp_a [4];
        //            we re addr        wdata        ack mrdata       stall rdata        req mwe maddr      mwdata
        vecs[0]  = mk(1, 0, 32'h40,  32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[1]  = mk(0, 1, 32'h40,  32'h0,        0, 32'h0,        0, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0);
        vecs[2]  = mk(0, 1, 32'h42,  32'h0,        0, 32'h0,        0, 32'hDEADBEEF, 1, 1, 32'h40,  32'hDEADBEEF);
        vecs[3]  = mk(0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 32'h0,        1, 1, 32'h40,  32'hDEADBEEF);
        vecs[4]  = mk(0, 1, 32'h40,  32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[5]  = mk(0, 1, 32'h40,  32'h0,        1, 32'hCAFEF00D, 1, 32'h0,        1, 0, 32'h40,  32'h0);
        vecs[6]  = mk(0, 1, 32'h40,  32'h0,        0, 32'h0,        0, 32'hCAFEF00D, 0, 0, 32'h0,   32'h0);
        vecs[7]  = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[8]  = mk(0, 1, 32'h200, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[9]  = mk(0, 1, 32'h200, 32'h0,        1, 32'h12345678, 1, 32'h0,        1, 0, 32'h200, 32'h0);
        vecs[10] = mk(0, 1, 32'h200, 32'h0,        0, 32'h0,        0, 32'h12345678, 0, 0, 32'h0,   32'h0);
        vecs[11] = mk(1, 0, 32'h80,  32'h1,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[12] = mk(1, 0, 32'h80,  32'h2,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[13] = mk(0, 1, 32'h80,  32'h0,        0, 32'h0,        0, 32'h2,        1, 1, 32'h80,  32'h1);
        vecs[14] = mk(0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 32'h0,        1, 1, 32'h80,  32'h1);
        vecs[15] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0);
        vecs[16] = mk(0, 0, 32'h0,   32'h0,        1, 32'h0,        0, 32'h0,        1, 1, 32'h80,  32'h2);
        vecs[17] = mk(0, 0, 32'h0,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0);

        reset = 1'b0; cpu_we = 0; cpu_re = 0; mem_ack = 0;
        cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_rdata", cpu_rdata, 0);
        reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            cpu_we = vecs[i].we; cpu_re = vecs[i].re; cpu_addr = vecs[i].addr;
            cpu_wdata = vecs[i].wdata; mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrdata;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].re && !vecs[i].e_stall)
                chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_mwe", i), 32'(mem_we), 32'(vecs[i].e_mwe));
                chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].e_maddr);
            end
            if (vecs[i].e_req && vecs[i].e_mwe)
                chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].e_mwdata);
            step();
        end
        cpu_we = 0; cpu_re = 0; mem_ack = 0;

        // Fill the FIFO with the bus stalled, then overflow by one.
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1; cpu_addr = 32'h10 + 32'(4 * i); cpu_wdata = 32'hA0 + 32'(i);
            @(negedge clk);
            chk($sformatf("fill%0d_stall", i), 32'(cpu_stall), 0);
            step();
        end
        cpu_addr = 32'h20; cpu_wdata = 32'hA4;
        @(negedge clk);
        chk("full_stall", 32'(cpu_stall), 1);
        chk("full_head_addr", mem_addr, 32'h10);
        step();
        mem_ack = 1;
        @(negedge clk);
        chk("ack_cycle_stall", 32'(cpu_stall), 1);
        step();
        mem_ack = 0;
        @(negedge clk);
        chk("enq_after_free", 32'(cpu_stall), 0);
        step();
        cpu_addr = 32'h24; cpu_wdata = 32'hA5;
        @(negedge clk);
        chk("full_again", 32'(cpu_stall), 1);
        cpu_we = 0;
        exp_a[0] = 32'h14; exp_a[1] = 32'h18; exp_a[2] = 32'h1C; exp_a[3] = 32'h20;
        for (int i = 0; i < 4; i++) begin
            wait_req(ok);
            chk($sformatf("drain%0d_seen", i), 32'(ok), 1);
            chk($sformatf("drain%0d_we", i), 32'(mem_we), 1);
            chk($sformatf("drain%0d_addr", i), mem_addr, exp_a[i]);
            chk($sformatf("drain%0d_data", i), mem_wdata, 32'hA1 + 32'(i));
            mem_ack = 1;
            step();
            mem_ack = 0;
        end
        quiet("drained_no_req");

        // Load miss arriving while a write drains.
        cpu_we = 1; cpu_addr = 32'h300; cpu_wdata = 32'h55;
        step();
        cpu_we = 0;
        wait_req(ok);
        chk("dr_seen", 32'(ok), 1);
        chk("dr_write", 32'(mem_we), 1);
        chk("dr_addr", mem_addr, 32'h300);
        cpu_re = 1; cpu_addr = 32'h500;
        #1;
        chk("dr_miss_stall", 32'(cpu_stall), 1);
        step();
        @(negedge clk);
        chk("dr_still_write", 32'(mem_we), 1);
        chk("dr_still_req", 32'(mem_req), 1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        @(negedge clk);
        chk("dr_idle_gap", 32'(mem_req), 0);
        chk("dr_gap_stall", 32'(cpu_stall), 1);
        @(negedge clk);
        chk("dr_read_req", 32'(mem_req), 1);
        chk("dr_read_we", 32'(mem_we), 0);
        chk("dr_read_addr", mem_addr, 32'h500);
        mem_ack = 1; mem_rdata = 32'h77;
        step();
        mem_ack = 0;
        @(negedge clk);
        chk("dr_resp_stall", 32'(cpu_stall), 0);
        chk("dr_resp_data", cpu_rdata, 32'h77);
        cpu_re = 0;
        quiet("dr_no_extra_req");

        // Reset while a write is on the bus.
        cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'h99;
        step();
        cpu_we = 0;
        wait_req(ok);
        chk("rd_seen", 32'(ok), 1);
        cpu_re = 1; cpu_addr = 32'h100;
        #1;
        reset = 1'b0;
        #1;
        chk("rd_req", 32'(mem_req), 0);
        chk("rd_we", 32'(mem_we), 0);
        chk("rd_addr", mem_addr, 0);
        chk("rd_wdata", mem_wdata, 0);
        chk("rd_stall", 32'(cpu_stall), 0);
        chk("rd_rdata", cpu_rdata, 0);
        @(negedge clk);
        reset = 1'b1; cpu_re = 0; mem_ack = 1;
        step();
        mem_ack = 0;
        quiet("rd_no_req_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
